// File: rtl/uart_pkg.sv
// uart_pkg -- shared types for the UART transmitter.
//   parity_e : latched parity selection for a frame (NONE, EVEN, ODD)
//   state_e  : transmitter frame state machine encoding
//   decode_parity : maps the raw 2-bit parity_mode input onto parity_e
//   effective_div : selects the per-frame bit period (0 picks the default)
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Mode 3 is reserved and behaves exactly like "no parity".
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return EVEN;
      2'd2:    return ODD;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [15:0] effective_div(input logic [15:0] baud_div,
                                                input logic [15:0] def_div);
    return (baud_div == 16'd0) ? def_div : baud_div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo -- synchronous single-clock FIFO used as the transmit queue.
//   clk, rst    : clock, asynchronous active-high reset (pointers/count only)
//   push, din   : write request and data; ignored while full
//   pop, dout   : read request and head-of-queue data (combinational read);
//                 pop is ignored while empty
//   full, empty : occupancy flags derived from the registered count
//   level       : current number of stored words (0..DEPTH)
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; a word only becomes visible once
  // count covers it, so clearing it would add reset fan-out for no benefit.
  // Sequential state is always assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param -- queued, parameterised UART transmitter.
//   clk, rst      : clock, asynchronous active-high reset
//   tx_data       : payload word (DATA_BITS), sent LSB first
//   tx_data_valid : push request; one word accepted per cycle while tx_ready
//   tx_ready      : queue not full
//   parity_mode   : 0 none, 1 even, 2 odd, 3 none (latched per frame)
//   stop2         : 0 one stop bit, 1 two stop bits (latched per frame)
//   baud_div      : bit period in clocks, 0 selects CLK_FREQ/BAUD_RATE
//                   (latched per frame)
//   tx            : registered serial line, idle high
//   busy          : frame in progress or queue non-empty
//   fifo_level    : queue occupancy
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic [15:0]                   baud_div,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [15:0]   DEF_DIV  = 16'(CLK_FREQ / BAUD_RATE);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_e                 state;
  state_e                 state_next;
  logic [15:0]            cyc_cnt;
  logic [15:0]            cyc_next;
  logic [BW-1:0]          bit_cnt;
  logic [BW-1:0]          bit_next;
  logic                   tx_next;
  logic                   pop;
  logic                   bit_done;
  logic                   par_bit;

  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Frame configuration captured at the pop so mid-frame input changes
  // only affect the next frame.
  logic [DATA_BITS-1:0]   data_q;
  parity_e                par_q;
  logic                   stop2_q;
  logic [15:0]            div_q;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_data_valid),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_done = (cyc_cnt == div_q - 16'd1);
  assign par_bit  = (^data_q) ^ (par_q == ODD);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cyc_next   = cyc_cnt;
    bit_next   = bit_cnt;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
          cyc_next   = '0;
          bit_next   = '0;
        end
      end

      START: begin
        if (bit_done) begin
          cyc_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          cyc_next = cyc_cnt + 16'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          cyc_next = '0;
          if (bit_cnt == LAST_BIT) begin
            bit_next   = '0;
            state_next = (par_q == NONE) ? STOP : PARITY;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          cyc_next = cyc_cnt + 16'd1;
        end
      end

      PARITY: begin
        if (bit_done) begin
          cyc_next   = '0;
          bit_next   = '0;
          state_next = STOP;
        end else begin
          cyc_next = cyc_cnt + 16'd1;
        end
      end

      STOP: begin
        if (bit_done) begin
          cyc_next = '0;
          // bit_cnt counts stop bits here; a second one is only for stop2.
          if (stop2_q && bit_cnt == '0) begin
            bit_next = BW'(1);
          end else begin
            bit_next = '0;
            if (!fifo_empty) begin
              pop        = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end
        end else begin
          cyc_next = cyc_cnt + 16'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    // tx is derived from the upcoming state so the line and the state
    // register change on the same edge.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[bit_next];
      PARITY:  tx_next = par_bit;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      cyc_cnt <= cyc_next;
      bit_cnt <= bit_next;
      tx      <= tx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      par_q   <= NONE;
      stop2_q <= 1'b0;
      div_q   <= DEF_DIV;
    end else if (pop) begin
      data_q  <= fifo_dout;
      par_q   <= decode_parity(parity_mode);
      stop2_q <= stop2;
      div_q   <= effective_div(baud_div, DEF_DIV);
    end
  end

  assign tx_ready = !fifo_full;
  assign busy     = (state != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param -- directed self-checking bench for uart_tx_param
// (default parameters: DEF_DIV = 868, DATA_BITS = 8, FIFO_DEPTH = 16).
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_ready;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [15:0] baud_div;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_param dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_ready      (tx_ready),
    .parity_mode   (parity_mode),
    .stop2         (stop2),
    .baud_div      (baud_div),
    .tx            (tx),
    .busy          (busy),
    .fifo_level    (fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one word across the next rising edge; back-to-back calls keep
  // valid high continuously.
  task automatic push_word(input logic [7:0] d);
    tx_data       = d;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
  endtask

  // Returns at the first falling edge where tx is low (cycle 0 of a start bit).
  task automatic wait_start(input string tag, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  // Entered at cycle 0 of a start bit; checks the first and last cycle of
  // every line bit and returns at the cycle right after the frame.
  task automatic check_frame(input string tag, input logic [15:0] pattern,
                             input int nbits, input int div);
    for (int k = 0; k < nbits; k++) begin
      check($sformatf("%s_b%0d_first", tag, k), 32'(tx), 32'(pattern[k]));
      repeat (div - 1) @(negedge clk);
      check($sformatf("%s_b%0d_last", tag, k), 32'(tx), 32'(pattern[k]));
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         accepted;
    int         low_cnt;
    logic [7:0] jb;

    rst           = 1'b1;
    tx_data       = '0;
    tx_data_valid = 1'b0;
    parity_mode   = 2'd0;
    stop2         = 1'b0;
    baud_div      = 16'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx",    32'(tx),         32'd1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_ready", 32'(tx_ready),   32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Default divisor (868), 8N1, 0x55
    push_word(8'h55);
    wait_start("t1", 50);
    check_frame("t1", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 868);
    check("t1_idle_tx", 32'(tx),   32'd1);
    check("t1_busy",    32'(busy), 32'd0);

    // Parity even / odd / reserved on 0x07, divisor 16
    baud_div    = 16'd16;
    parity_mode = 2'd1;
    push_word(8'h07);
    wait_start("t2e", 50);
    check_frame("t2e", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 16);
    check("t2e_idle", 32'(tx), 32'd1);

    parity_mode = 2'd2;
    push_word(8'h07);
    wait_start("t2o", 50);
    check_frame("t2o", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 16);
    check("t2o_idle", 32'(tx), 32'd1);

    parity_mode = 2'd3;
    push_word(8'h07);
    wait_start("t2n", 50);
    check_frame("t2n", {6'b0, 1'b1, 8'h07, 1'b0}, 10, 16);
    check("t2n_idle", 32'(tx),   32'd1);
    check("t2n_busy", 32'(busy), 32'd0);

    // Two stop bits, back-to-back frames with no gap (176 clocks each)
    parity_mode = 2'd0;
    stop2       = 1'b1;
    push_word(8'hA3);
    push_word(8'h3C);
    check_frame("t3a", {5'b0, 2'b11, 8'hA3, 1'b0}, 11, 16);
    check("t3_no_gap", 32'(tx), 32'd0);
    check_frame("t3b", {5'b0, 2'b11, 8'h3C, 1'b0}, 11, 16);
    check("t3_idle", 32'(tx),   32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    stop2 = 1'b0;

    // Fill the queue while a frame is on the line
    push_word(8'hFF);
    wait_start("t4", 50);
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      tx_data       = 8'(i);
      tx_data_valid = 1'b1;
      check($sformatf("t4_ready_c%0d", i), 32'(tx_ready), 32'(i < 16));
      if (tx_ready) accepted++;
      @(negedge clk);
    end
    tx_data_valid = 1'b0;
    check("t4_accepted", 32'(accepted),   32'd16);
    check("t4_level",    32'(fifo_level), 32'd16);
    check("t4_ready",    32'(tx_ready),   32'd0);
    repeat (160 - 20) @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      jb = 8'(j);
      check_frame($sformatf("t4w%0d", j), {6'b0, 1'b1, jb, 1'b0}, 10, 16);
    end
    check("t4_idle",  32'(tx),         32'd1);
    check("t4_busy",  32'(busy),       32'd0);
    check("t4_empty", 32'(fifo_level), 32'd0);

    // Reset in the middle of data bit 4 with three words queued
    push_word(8'h00);
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    check("t5_level_pre", 32'(fifo_level), 32'd3);
    repeat (86) @(negedge clk);
    check("t5_tx_pre", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("t5_tx",    32'(tx),         32'd1);
    check("t5_level", 32'(fifo_level), 32'd0);
    check("t5_busy",  32'(busy),       32'd0);
    check("t5_ready", 32'(tx_ready),   32'd1);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    low_cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("t5_no_frames", 32'(low_cnt), 32'd0);
    check("t5_busy_post", 32'(busy),    32'd0);

    // Divisor and parity changed mid-frame apply only to the next frame
    baud_div = 16'd16;
    push_word(8'h96);
    push_word(8'h01);
    baud_div    = 16'd32;
    parity_mode = 2'd1;
    check_frame("t6a", {6'b0, 1'b1, 8'h96, 1'b0}, 10, 16);
    check("t6_no_gap", 32'(tx), 32'd0);
    check_frame("t6b", {5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 32);
    check("t6_idle", 32'(tx),   32'd1);
    check("t6_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
